// File: rtl/mem_wait_pkg.sv
// rtl/mem_wait_pkg.sv - shared types and default widths for the memory wait controller
package mem_wait_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ADDR_W_DEF  = 16;
  localparam int DATA_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 64;
  localparam int CNT_W_DEF   = 16;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter, holds at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] value
);

  logic [W-1:0] value_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
    end else if (inc && (value_q != '1)) begin
      value_q <= value_q + W'(1);
    end
  end

  assign value = value_q;

endmodule

// File: rtl/mem_wait_ctrl.sv
// rtl/mem_wait_ctrl.sv - stalls a pipeline access across a multi-cycle memory req/ready handshake
module mem_wait_ctrl
  import mem_wait_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              access_req,
  input  logic              access_we,
  input  logic [ADDR_W-1:0] access_addr,
  input  logic [DATA_W-1:0] access_wdata,
  output logic              stall,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int WCNT_W = $clog2(TIMEOUT);
  localparam logic [WCNT_W-1:0] WAIT_LIMIT = WCNT_W'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                timeout_err_q, timeout_err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      rdata_q       <= '0;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      rdata_q       <= rdata_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    rdata_d       = rdata_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;
    unique case (state_q)
      IDLE: begin
        if (access_req) begin
          state_d     = BUSY;
          mem_we_d    = access_we;
          mem_addr_d  = access_addr;
          mem_wdata_d = access_wdata;
          wait_cnt_d  = '0;
        end
      end
      BUSY: begin
        // ready takes priority over a timeout landing in the same cycle
        if (mem_ready) begin
          state_d = DONE;
          if (!mem_we_q) rdata_d = mem_rdata;
        end else if (wait_cnt_q == WAIT_LIMIT) begin
          state_d       = DONE;
          timeout_err_d = 1'b1;
          rdata_d       = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign stall       = ((state_q == IDLE) && access_req) || (state_q == BUSY);
  assign mem_req     = (state_q == BUSY);
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign rdata       = rdata_q;
  assign timeout_err = timeout_err_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall),
    .value (stall_cycles)
  );

endmodule

// File: tb/tb_mem_wait_ctrl.sv
// tb/tb_mem_wait_ctrl.sv - directed self-checking bench for mem_wait_ctrl
module tb_mem_wait_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        access_we;
  logic [15:0] access_addr, access_wdata, mem_rdata;

  logic        access_req_a, mem_ready_a;
  logic        stall_a, mem_req_a, mem_we_a, timeout_err_a;
  logic [15:0] rdata_a, mem_addr_a, mem_wdata_a, stall_cycles_a;

  logic        access_req_b, mem_ready_b;
  logic        stall_b, mem_req_b, mem_we_b, timeout_err_b;
  logic [15:0] rdata_b, mem_addr_b, mem_wdata_b;
  logic [2:0]  stall_cycles_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_wait_ctrl #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(8), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .access_req(access_req_a), .access_we(access_we),
    .access_addr(access_addr), .access_wdata(access_wdata), .stall(stall_a),
    .rdata(rdata_a), .mem_req(mem_req_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .mem_ready(mem_ready_a), .mem_rdata(mem_rdata),
    .timeout_err(timeout_err_a), .stall_cycles(stall_cycles_a)
  );

  mem_wait_ctrl #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(4), .CNT_W(3)) u_b (
    .clk(clk), .rst(rst), .access_req(access_req_b), .access_we(access_we),
    .access_addr(access_addr), .access_wdata(access_wdata), .stall(stall_b),
    .rdata(rdata_b), .mem_req(mem_req_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_ready(mem_ready_b), .mem_rdata(mem_rdata),
    .timeout_err(timeout_err_b), .stall_cycles(stall_cycles_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    access_we = 1'b0; access_addr = '0; access_wdata = '0; mem_rdata = '0;
    access_req_a = 1'b0; mem_ready_a = 1'b0;
    access_req_b = 1'b0; mem_ready_b = 1'b0;
    tick(); tick();
    chk("rst_mem_req", {31'd0, mem_req_a}, 32'd0);
    chk("rst_stall", {31'd0, stall_a}, 32'd0);
    chk("rst_rdata", {16'd0, rdata_a}, 32'd0);
    chk("rst_cnt", {16'd0, stall_cycles_a}, 32'd0);
    chk("rst_terr", {31'd0, timeout_err_a}, 32'd0);
    rst = 1'b0;
    tick();

    // 1: load with ready in the first BUSY cycle
    access_req_a = 1'b1; access_we = 1'b0; access_addr = 16'h0040; #1;
    chk("t1_idle_stall", {31'd0, stall_a}, 32'd1);
    chk("t1_idle_req", {31'd0, mem_req_a}, 32'd0);
    tick();
    mem_ready_a = 1'b1; mem_rdata = 16'hBEEF; #1;
    chk("t1_busy_stall", {31'd0, stall_a}, 32'd1);
    chk("t1_busy_req", {31'd0, mem_req_a}, 32'd1);
    chk("t1_busy_addr", {16'd0, mem_addr_a}, 32'h0040);
    chk("t1_busy_we", {31'd0, mem_we_a}, 32'd0);
    tick();
    access_req_a = 1'b0; mem_ready_a = 1'b0; mem_rdata = 16'h0000; #1;
    chk("t1_done_stall", {31'd0, stall_a}, 32'd0);
    chk("t1_done_req", {31'd0, mem_req_a}, 32'd0);
    chk("t1_done_rdata", {16'd0, rdata_a}, 32'hBEEF);
    chk("t1_done_cnt", {16'd0, stall_cycles_a}, 32'd2);
    tick();

    // 2: store, ready on the fifth BUSY cycle; pipeline inputs wander meanwhile
    access_req_a = 1'b1; access_we = 1'b1; access_addr = 16'h0010; access_wdata = 16'h1234; #1;
    chk("t2_idle_stall", {31'd0, stall_a}, 32'd1);
    tick();
    access_we = 1'b0; access_addr = 16'hFFFF; access_wdata = 16'hAAAA; mem_rdata = 16'h5555;
    for (int i = 0; i < 5; i++) begin
      mem_ready_a = (i == 4); #1;
      chk($sformatf("t2_busy%0d_req", i), {31'd0, mem_req_a}, 32'd1);
      chk($sformatf("t2_busy%0d_stall", i), {31'd0, stall_a}, 32'd1);
      chk($sformatf("t2_busy%0d_we", i), {31'd0, mem_we_a}, 32'd1);
      chk($sformatf("t2_busy%0d_addr", i), {16'd0, mem_addr_a}, 32'h0010);
      chk($sformatf("t2_busy%0d_wdata", i), {16'd0, mem_wdata_a}, 32'h1234);
      tick();
    end
    access_req_a = 1'b0; mem_ready_a = 1'b0; #1;
    chk("t2_done_stall", {31'd0, stall_a}, 32'd0);
    chk("t2_done_rdata", {16'd0, rdata_a}, 32'hBEEF);
    chk("t2_done_cnt", {16'd0, stall_cycles_a}, 32'd8);
    chk("t2_done_terr", {31'd0, timeout_err_a}, 32'd0);
    tick();

    // 4: back-to-back loads with access_req held high throughout
    access_req_a = 1'b1; access_we = 1'b0; access_addr = 16'h0020; #1;
    chk("t4_idle0_stall", {31'd0, stall_a}, 32'd1);
    chk("t4_idle0_req", {31'd0, mem_req_a}, 32'd0);
    tick();
    mem_ready_a = 1'b1; mem_rdata = 16'h1111; #1;
    chk("t4_busy0_req", {31'd0, mem_req_a}, 32'd1);
    tick();
    mem_ready_a = 1'b0; access_addr = 16'h0022; #1;
    chk("t4_done0_stall", {31'd0, stall_a}, 32'd0);
    chk("t4_done0_req", {31'd0, mem_req_a}, 32'd0);
    chk("t4_done0_rdata", {16'd0, rdata_a}, 32'h1111);
    tick();
    chk("t4_idle1_stall", {31'd0, stall_a}, 32'd1);
    chk("t4_idle1_req", {31'd0, mem_req_a}, 32'd0);
    tick();
    mem_ready_a = 1'b1; mem_rdata = 16'h2222; #1;
    chk("t4_busy1_req", {31'd0, mem_req_a}, 32'd1);
    chk("t4_busy1_addr", {16'd0, mem_addr_a}, 32'h0022);
    tick();
    access_req_a = 1'b0; mem_ready_a = 1'b0; #1;
    chk("t4_done1_stall", {31'd0, stall_a}, 32'd0);
    chk("t4_done1_rdata", {16'd0, rdata_a}, 32'h2222);
    chk("t4_done1_cnt", {16'd0, stall_cycles_a}, 32'd12);
    tick();

    // 6 + ready at the timeout limit: B has TIMEOUT=4, CNT_W=3
    access_req_b = 1'b1; access_addr = 16'h0030; #1;
    chk("tb_idle_stall", {31'd0, stall_b}, 32'd1);
    tick(); tick(); tick(); tick();
    mem_ready_b = 1'b1; mem_rdata = 16'hA5A5; #1;
    chk("tb_lim_req", {31'd0, mem_req_b}, 32'd1);
    tick();
    access_req_b = 1'b0; mem_ready_b = 1'b0; #1;
    chk("tb_lim_rdata", {16'd0, rdata_b}, 32'hA5A5);
    chk("tb_lim_terr", {31'd0, timeout_err_b}, 32'd0);
    chk("tb_lim_cnt", {29'd0, stall_cycles_b}, 32'd5);
    chk("tb_lim_stall", {31'd0, stall_b}, 32'd0);
    tick();

    // 3: timeout with mem_ready never asserted
    access_req_b = 1'b1; access_addr = 16'h0034; #1;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_busy%0d_req", i), {31'd0, mem_req_b}, 32'd1);
      tick();
    end
    access_req_b = 1'b0; #1;
    chk("t3_done_stall", {31'd0, stall_b}, 32'd0);
    chk("t3_done_req", {31'd0, mem_req_b}, 32'd0);
    chk("t3_done_terr", {31'd0, timeout_err_b}, 32'd1);
    chk("t3_done_rdata", {16'd0, rdata_b}, 32'd0);
    chk("t6_sat_cnt", {29'd0, stall_cycles_b}, 32'd7);
    tick();
    access_req_b = 1'b1; access_addr = 16'h0038; #1;
    tick();
    mem_ready_b = 1'b1; mem_rdata = 16'h5A5A; #1;
    tick();
    access_req_b = 1'b0; mem_ready_b = 1'b0; #1;
    chk("t3_next_rdata", {16'd0, rdata_b}, 32'h5A5A);
    chk("t3_next_terr", {31'd0, timeout_err_b}, 32'd1);
    chk("t6_hold_cnt", {29'd0, stall_cycles_b}, 32'd7);
    tick();

    // 5: async reset between edges during BUSY
    access_req_a = 1'b1; access_addr = 16'h0050; #1;
    tick();
    chk("t5_busy_req", {31'd0, mem_req_a}, 32'd1);
    chk("t5_busy_addr", {16'd0, mem_addr_a}, 32'h0050);
    #2;
    rst = 1'b1; access_req_a = 1'b0; #1;
    chk("t5_rst_req", {31'd0, mem_req_a}, 32'd0);
    chk("t5_rst_stall", {31'd0, stall_a}, 32'd0);
    chk("t5_rst_cnt", {16'd0, stall_cycles_a}, 32'd0);
    chk("t5_rst_addr", {16'd0, mem_addr_a}, 32'd0);
    chk("t5_rst_rdata", {16'd0, rdata_a}, 32'd0);
    chk("t5_rst_terr_b", {31'd0, timeout_err_b}, 32'd0);
    chk("t5_rst_cnt_b", {29'd0, stall_cycles_b}, 32'd0);
    tick();
    rst = 1'b0; mem_ready_a = 1'b1; mem_rdata = 16'h7777; #1;
    tick();
    chk("t5_late_req", {31'd0, mem_req_a}, 32'd0);
    chk("t5_late_stall", {31'd0, stall_a}, 32'd0);
    chk("t5_late_rdata", {16'd0, rdata_a}, 32'd0);
    chk("t5_late_cnt", {16'd0, stall_cycles_a}, 32'd0);
    mem_ready_a = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
